fir_channel_scheduler: RTL

Sequences a single multi-channel band-pass FIR core (Avalon-ST sink/source, 16-bit in, 34-bit out) across NUM_CH beamformer microphone channels. The core is configured for NUM_CH interleaved channels and requires its input strictly in cyclic channel order 0,1,…,NUM_CH-1. This block buffers one sample per channel, issues samples to the core in that order, and demultiplexes core outputs back to per-channel registers. It sits between the ADC capture front end and the delay-and-sum stage.

---
 rtl/fir_sched_pkg.sv | 19 +
 rtl/fir_sched_hold.sv | 44 ++++
 rtl/fir_channel_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fir_sched_pkg.sv
// Shared definitions for the FIR channel scheduler: default widths,
// channel index type and error-flag bit positions.
package fir_sched_pkg;

  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_DIN_W        = 16;
  localparam int DEF_DOUT_W       = 34;
  localparam int DEF_MAX_INFLIGHT = 32;

  // Channel index sized for the default channel count.
  localparam int CH_IDX_W = (DEF_NUM_CH > 1) ? $clog2(DEF_NUM_CH) : 1;
  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  // Bit positions inside the packed sticky error register.
  localparam int ERR_STALL_BIT  = 0;
  localparam int ERR_ORPHAN_BIT = 1;
  localparam int ERR_W          = 2;

endpackage

// File: rtl/fir_sched_hold.sv
// One-deep per-channel holding register. Ready while empty; a held
// sample stays until the scheduler issues it, new offers are ignored.
module fir_sched_hold
  import fir_sched_pkg::*;
#(
  parameter int DIN_W = DEF_DIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DIN_W-1:0] in_data,
  input  logic             issue,
  output logic             ready,
  output logic             pend,
  output logic [DIN_W-1:0] data
);

  logic             pend_reg;
  logic [DIN_W-1:0] data_reg;
  logic             accept;

  // Ready reflects the registered pend only, so there is no bypass path.
  always_comb begin
    accept = in_valid & ~pend_reg;
  end

  // Capture on accept; release the slot when the scheduler issues it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_reg <= 1'b0;
      data_reg <= '0;
    end else if (accept) begin
      data_reg <= in_data;
      pend_reg <= 1'b1;
    end else if (issue) begin
      pend_reg <= 1'b0;
    end
  end

  assign ready = ~pend_reg;
  assign pend  = pend_reg;
  assign data  = data_reg;

endmodule

// File: rtl/fir_channel_scheduler.sv
// Feeds a multi-channel interleaved FIR core strictly in cyclic channel
// order from per-channel holding registers, and demultiplexes the core
// results back to per-channel output registers.
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int DIN_W        = DEF_DIN_W,
  parameter int DOUT_W       = DEF_DOUT_W,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DIN_W-1:0]  ch_data,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [DIN_W-1:0]         filt_sink_data,
  output logic                     filt_sink_valid,
  output logic [1:0]               filt_sink_error,
  input  logic [DOUT_W-1:0]        filt_source_data,
  input  logic                     filt_source_valid,
  output logic [NUM_CH*DOUT_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  output logic                     stall_err,
  output logic                     orphan_err
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CH_W-1:0] LAST_SLOT = CH_W'(NUM_CH - 1);
  localparam logic [IF_W-1:0] IF_MAX    = IF_W'(MAX_INFLIGHT);

  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] issue_ch;
  logic [DIN_W-1:0]  hold_data [NUM_CH];

  logic [CH_W-1:0]   in_slot_reg;
  logic [CH_W-1:0]   out_slot_reg;
  logic [IF_W-1:0]   inflight_reg;
  logic [DIN_W-1:0]  sink_data_reg;
  logic              sink_valid_reg;
  logic [DOUT_W-1:0] out_data_reg [NUM_CH];
  logic [NUM_CH-1:0] out_valid_reg;
  logic [ERR_W-1:0]  err_reg;

  logic slot_pend;
  logic room;
  logic issue;
  logic blocked;
  logic result;
  logic orphan;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_hold
      fir_sched_hold #(
        .DIN_W (DIN_W)
      ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (ch_valid[gi]),
        .in_data  (ch_data[gi*DIN_W +: DIN_W]),
        .issue    (issue_ch[gi]),
        .ready    (ch_ready[gi]),
        .pend     (pend[gi]),
        .data     (hold_data[gi])
      );
      assign out_data[gi*DOUT_W +: DOUT_W] = out_data_reg[gi];
    end
  endgenerate

  // Issue decision: wait on the current slot, never skip ahead.
  always_comb begin
    slot_pend = pend[in_slot_reg];
    room      = (inflight_reg < IF_MAX);
    issue     = en & slot_pend & room;
    blocked   = en & slot_pend & ~room;
    result    = filt_source_valid & (inflight_reg != '0);
    orphan    = filt_source_valid & (inflight_reg == '0);
    issue_ch  = '0;
    issue_ch[in_slot_reg] = issue;
  end

  // Registered sink strobe/data and the cyclic issue slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_slot_reg    <= '0;
      sink_valid_reg <= 1'b0;
      sink_data_reg  <= '0;
    end else begin
      sink_valid_reg <= issue;
      if (issue) begin
        sink_data_reg <= hold_data[in_slot_reg];
        in_slot_reg   <= (in_slot_reg == LAST_SLOT) ? '0 : in_slot_reg + 1'b1;
      end
    end
  end

  // Count of samples handed to the core whose result has not come back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      inflight_reg <= '0;
    end else begin
      case ({issue, result})
        2'b10:   inflight_reg <= inflight_reg + 1'b1;
        2'b01:   inflight_reg <= inflight_reg - 1'b1;
        default: inflight_reg <= inflight_reg;
      endcase
    end
  end

  // Route each core result to the next channel in cyclic order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_slot_reg  <= '0;
      out_valid_reg <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        out_data_reg[i] <= '0;
      end
    end else begin
      out_valid_reg <= '0;
      if (result) begin
        out_data_reg[out_slot_reg]  <= filt_source_data;
        out_valid_reg[out_slot_reg] <= 1'b1;
        out_slot_reg <= (out_slot_reg == LAST_SLOT) ? '0 : out_slot_reg + 1'b1;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_reg <= '0;
    end else begin
      if (blocked) err_reg[ERR_STALL_BIT]  <= 1'b1;
      if (orphan)  err_reg[ERR_ORPHAN_BIT] <= 1'b1;
    end
  end

  assign filt_sink_data  = sink_data_reg;
  assign filt_sink_valid = sink_valid_reg;
  assign filt_sink_error = 2'b00;
  assign out_valid       = out_valid_reg;
  assign stall_err       = err_reg[ERR_STALL_BIT];
  assign orphan_err      = err_reg[ERR_ORPHAN_BIT];

endmodule
